// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Register file with write-to-read bypass, a hardwired zero register
//            and a per-register pending-write scoreboard for load-use stalls.
// Revision : 1.0
// ============================================================================
module regfile_scoreboard #(
    parameter int WIDTH    = 64,
    parameter int AW       = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = (1 << AW) - 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]       rd_pending,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   claim_en,
    input  logic [AW-1:0]          claim_addr,
    output logic [AW:0]            pend_count
);

    localparam int            c_depth     = 1 << AW;
    localparam logic [AW-1:0] c_zero_addr = AW'(ZERO_REG);

    logic [WIDTH-1:0]   r_regs [c_depth];
    logic [c_depth-1:0] r_pend;
    logic [AW:0]        r_pend_count;

    logic               w_wr_ok;
    logic               w_claim_ok;
    logic [c_depth-1:0] w_pend_next;
    logic [AW:0]        w_pend_cnt;

    assign w_wr_ok    = wr_en && (wr_addr != c_zero_addr);
    assign w_claim_ok = claim_en && (claim_addr != c_zero_addr);

    // Claim is applied after the write so a same-edge claim (younger producer) wins.
    always_comb begin
        w_pend_next = r_pend;
        if (w_wr_ok) begin
            w_pend_next[wr_addr] = 1'b0;
        end
        if (w_claim_ok) begin
            w_pend_next[claim_addr] = 1'b1;
        end
        w_pend_cnt = '0;
        for (int i = 0; i < c_depth; i++) begin
            w_pend_cnt = w_pend_cnt + (AW+1)'(w_pend_next[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_regs[i] <= '0;
            end
            r_pend       <= '0;
            r_pend_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[wr_addr] <= wr_data;
            end
            r_pend       <= w_pend_next;
            r_pend_count <= w_pend_cnt;
        end
    end

    assign pend_count = r_pend_count;

    // Bypass is suppressed during reset so every port reads zero while it is held.
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_hit;
        logic          w_is_zero;

        assign w_addr    = rd_addr[k*AW +: AW];
        assign w_is_zero = (w_addr == c_zero_addr);
        assign w_hit     = wr_en && !reset && (wr_addr == w_addr);

        assign rd_data[k*WIDTH +: WIDTH] = w_is_zero ? {WIDTH{1'b0}} :
                                           w_hit     ? wr_data :
                                                       r_regs[w_addr];
        assign rd_pending[k] = r_pend[w_addr] & ~w_hit & ~w_is_zero;
    end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file for the pipelined CPU datapath. It has a configurable data width, address width and number of read ports, and keeps the ARM zero register hardwired. It adds two things: same-cycle write-to-read bypass, and a per-register pending-write scoreboard so the decode stage can detect load-use hazards and stall. It sits between decode (read addresses, claims) and writeback (write port).

## Interface
Parameters:
- WIDTH, 64, data width of each register
- AW, 5, register address width; depth = 2^AW
- NREAD, 2, number of independent combinational read ports
- ZERO_REG, 2^AW-1 (31 at defaults), index that always reads 0 and ignores writes and claims

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- rd_addr  in  NREAD*AW  read addresses; port k = rd_addr[k*AW +: AW]
- rd_data  out  NREAD*WIDTH  read data; port k = rd_data[k*WIDTH +: WIDTH]
- rd_pending  out  NREAD  bit k = register at rd_addr port k has an outstanding write
- wr_en  in  1  writeback enable
- wr_addr  in  AW  writeback register index
- wr_data  in  WIDTH  writeback value
- claim_en  in  1  decode issues a producer (e.g. LDUR) targeting claim_addr
- claim_addr  in  AW  register being claimed
- pend_count  out  AW+1  registered count of set pending bits

## Operation
- Storage: 2^AW x WIDTH registers and 2^AW pending bits. The entry at ZERO_REG is never written or set; it may be tied off.
- Reset: all registers 0, all pending bits 0, pend_count 0. Consequently rd_data = 0 and rd_pending = 0 for every port while reset is high.
- Read port k, combinational, evaluated in this priority order:
  - rd_addr_k == ZERO_REG: data is 0.
  - Otherwise, if wr_en and wr_addr == rd_addr_k: data is wr_data (bypass).
  - Otherwise: data is the stored value.
- rd_pending[k] = pending[rd_addr_k] & ~(wr_en & wr_addr == rd_addr_k). It is always 0 for ZERO_REG. A write arriving in the same cycle resolves the hazard.
- Write: on the edge with wr_en=1 and wr_addr != ZERO_REG, store wr_data and clear pending[wr_addr].
- Claim: on the edge with claim_en=1 and claim_addr != ZERO_REG, set pending[claim_addr].
- Same edge, claim and write to the same address: the data is written and pending ends at 1. The claim is the younger producer, so the claim wins.
- A claim on an already-pending register leaves it pending. No counting per register; a single write clears it.
- A write to a non-pending register is legal and leaves pending at 0.
- pend_count is the population count of the pending bits after the edge. It is updated every edge, is at most 2^AW-1, and is never negative.
- No X propagation: an out-of-range rd_addr cannot occur because the address is AW bits wide.

## Timing
- Read latency: 0 cycles, combinational from rd_addr, wr_en, wr_addr and wr_data.
- Write latency: stored at the rising edge and visible through storage from the next cycle. It is visible through the bypass in the same cycle.
- Claim latency: pending and pend_count reflect the claim from the cycle after the edge. A read of the claimed register in the claim cycle itself shows rd_pending = 0.
- Asynchronous reset asserted mid-operation clears storage, pending bits and pend_count without waiting for clk. Writes and claims presented in that cycle are discarded.
- Reset deassertion is synchronous to the design's reset synchroniser. The first edge after deassertion performs normal writes and claims.

## Test plan
- Reset then read all ports: pulse reset, set rd_addr to {3,7} -> rd_data {0,0}, rd_pending 00, pend_count 0.
- Write then read plus bypass:
  - Write X5=0xDEAD_BEEF_0000_0001 at edge 1; read X5 in cycle 2 -> 0xDEAD_BEEF_0000_0001.
  - In the same cycle, wr_en to X6=0x42 with rd_addr port 1 = 6 -> rd_data port 1 = 0x42 before the edge.
- Zero register:
  - Write X31=0xFFFF..FF and claim X31 -> reading X31 gives 0, rd_pending 0, pend_count unchanged.
- Load-use scoreboard:
  - Claim X9 at edge 1 -> cycle 2: rd_addr X9 gives rd_pending 1, pend_count 1.
  - Cycle 3: wr X9=0x77 while reading X9 -> rd_pending 0, rd_data 0x77.
  - After edge 3: pend_count 0.
- Simultaneous claim and write on X4 at one edge:
  - wr_data 0x10 -> stored 0x10, pending[4]=1, pend_count 1.
  - Separately, claim X2 and write X3 at the same edge -> pend_count +1.
- Async reset mid-run:
  - Claim X1, X2, X3 and write X1..X3 with nonzero values.
  - Assert reset between clock edges -> outputs 0 and pend_count 0 immediately, before the next edge.
  - Edges during reset leave the state cleared.
